// File: rtl/masked_event_counter_if.sv
// Bundles the event inputs, control strobes and counter/snapshot outputs of
// masked_event_counter so they travel as one port.
interface masked_event_counter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       data;
    logic                   mask_wr;
    logic [WIDTH-1:0]       mask_din;
    logic                   clr;
    logic                   snap_req;
    logic [WIDTH-1:0]       gated;
    logic [WIDTH*CNT_W-1:0] cnt;
    logic [WIDTH-1:0]       sat;
    logic [WIDTH*CNT_W-1:0] snap_data;
    logic                   snap_valid;

    modport master (
        output data, mask_wr, mask_din, clr, snap_req,
        input  gated, cnt, sat, snap_data, snap_valid
    );

    modport slave (
        input  data, mask_wr, mask_din, clr, snap_req,
        output gated, cnt, sat, snap_data, snap_valid
    );
endinterface

// File: rtl/masked_event_counter.sv
// Per-channel masked event counters with saturation, optional rising-edge
// qualification and a one-cycle snapshot port.
module masked_event_counter #(
    parameter int               WIDTH     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] MASK_RST  = {WIDTH{1'b1}},
    parameter int               EDGE_MODE = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    masked_event_counter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] gated_reg;
    logic [WIDTH-1:0] sat_reg;
    logic [WIDTH-1:0] sat_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] inc;
    logic [CNT_W-1:0] cnt_reg  [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [CNT_W-1:0] snap_reg [WIDTH];
    logic             snap_valid_reg;

    assign q = mask_reg & bus.data;

    // gated_reg doubles as the edge-detect history: it is last cycle's q.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            assign inc[gi] = (EDGE_MODE != 0) ? (q[gi] & ~gated_reg[gi]) : q[gi];
            assign bus.cnt[gi*CNT_W +: CNT_W]       = cnt_reg[gi];
            assign bus.snap_data[gi*CNT_W +: CNT_W] = snap_reg[gi];
        end
    endgenerate

    always_comb begin
        sat_next = sat_reg;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt_reg[i];
            if (bus.clr) begin
                cnt_next[i] = '0;
                sat_next[i] = 1'b0;
            end else if (inc[i]) begin
                if (cnt_reg[i] == CNT_MAX) begin
                    sat_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt_reg[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg       <= MASK_RST;
            gated_reg      <= '0;
            sat_reg        <= '0;
            snap_valid_reg <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i]  <= '0;
                snap_reg[i] <= '0;
            end
        end else begin
            if (bus.mask_wr) begin
                mask_reg <= bus.mask_din;
            end
            gated_reg      <= q;
            sat_reg        <= sat_next;
            snap_valid_reg <= bus.snap_req;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= cnt_next[i];
                // Snapshot takes the pre-increment, pre-clear value.
                if (bus.snap_req) begin
                    snap_reg[i] <= cnt_reg[i];
                end
            end
        end
    end

    assign bus.gated      = gated_reg;
    assign bus.sat        = sat_reg;
    assign bus.snap_valid = snap_valid_reg;
endmodule

// File: tb/tb_masked_event_counter.sv
// Drives three masked_event_counter configurations with shared stimulus and
// checks them against a rule-level reference model.
module tb_masked_event_counter;
    localparam int NCFG = 3;
    localparam int CW [NCFG] = '{8, 4, 8};
    localparam int EM [NCFG] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data;
    logic       mask_wr;
    logic [3:0] mask_din;
    logic       clr;
    logic       snap_req;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    masked_event_counter_if #(.WIDTH(4), .CNT_W(8)) if0 ();
    masked_event_counter_if #(.WIDTH(4), .CNT_W(4)) if1 ();
    masked_event_counter_if #(.WIDTH(4), .CNT_W(8)) if2 ();

    masked_event_counter #(.WIDTH(4), .CNT_W(8), .MASK_RST(4'hF), .EDGE_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    masked_event_counter #(.WIDTH(4), .CNT_W(4), .MASK_RST(4'hF), .EDGE_MODE(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    masked_event_counter #(.WIDTH(4), .CNT_W(8), .MASK_RST(4'hF), .EDGE_MODE(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.data = data;  assign if0.mask_wr = mask_wr;  assign if0.mask_din = mask_din;
    assign if0.clr  = clr;   assign if0.snap_req = snap_req;
    assign if1.data = data;  assign if1.mask_wr = mask_wr;  assign if1.mask_din = mask_din;
    assign if1.clr  = clr;   assign if1.snap_req = snap_req;
    assign if2.data = data;  assign if2.mask_wr = mask_wr;  assign if2.mask_din = mask_din;
    assign if2.clr  = clr;   assign if2.snap_req = snap_req;

    logic [15:0] c_o  [NCFG][4];
    logic [15:0] s_o  [NCFG][4];
    logic [3:0]  g_o  [NCFG];
    logic [3:0]  sat_o[NCFG];
    logic        sv_o [NCFG];

    assign g_o[0] = if0.gated;  assign sat_o[0] = if0.sat;  assign sv_o[0] = if0.snap_valid;
    assign g_o[1] = if1.gated;  assign sat_o[1] = if1.sat;  assign sv_o[1] = if1.snap_valid;
    assign g_o[2] = if2.gated;  assign sat_o[2] = if2.sat;  assign sv_o[2] = if2.snap_valid;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign c_o[0][gi] = {8'd0,  if0.cnt[gi*8 +: 8]};
            assign c_o[1][gi] = {12'd0, if1.cnt[gi*4 +: 4]};
            assign c_o[2][gi] = {8'd0,  if2.cnt[gi*8 +: 8]};
            assign s_o[0][gi] = {8'd0,  if0.snap_data[gi*8 +: 8]};
            assign s_o[1][gi] = {12'd0, if1.snap_data[gi*4 +: 4]};
            assign s_o[2][gi] = {8'd0,  if2.snap_data[gi*8 +: 8]};
        end
    endgenerate

    // Reference model: plain counts per channel following the counting rules.
    logic [3:0] m_mask;
    logic [3:0] m_prev_q;
    int         m_cnt [NCFG][4];
    bit         m_sat [NCFG][4];
    int         m_snap[NCFG][4];
    bit         m_sv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mask   <= 4'hF;
            m_prev_q <= 4'h0;
            m_sv     <= 1'b0;
            for (int c = 0; c < NCFG; c++) begin
                for (int i = 0; i < 4; i++) begin
                    m_cnt[c][i]  <= 0;
                    m_sat[c][i]  <= 1'b0;
                    m_snap[c][i] <= 0;
                end
            end
        end else begin
            m_mask   <= mask_wr ? mask_din : m_mask;
            m_prev_q <= m_mask & data;
            m_sv     <= snap_req;
            for (int c = 0; c < NCFG; c++) begin
                for (int i = 0; i < 4; i++) begin
                    if (snap_req) m_snap[c][i] <= m_cnt[c][i];
                    if (clr) begin
                        m_cnt[c][i] <= 0;
                        m_sat[c][i] <= 1'b0;
                    end else if (m_mask[i] && data[i] && (EM[c] == 0 || !m_prev_q[i])) begin
                        if (m_cnt[c][i] == (1 << CW[c]) - 1) m_sat[c][i] <= 1'b1;
                        else                                 m_cnt[c][i] <= m_cnt[c][i] + 1;
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        data = 4'h0; mask_wr = 1'b0; mask_din = 4'h0; clr = 1'b0; snap_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (g_o[c] !== 4'h0 || sat_o[c] !== 4'h0 || sv_o[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags cfg%0d: gated=%h sat=%h sv=%b required 0", c, g_o[c], sat_o[c], sv_o[c]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (c_o[c][i] !== 16'd0 || s_o[c][i] !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_cnt cfg%0d ch%0d: cnt=%0d snap=%0d required 0", c, i, c_o[c][i], s_o[c][i]);
                end
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_count();
        do_reset();
        data = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 1) begin
                checks++;
                if (g_o[0] !== 4'hF) begin
                    errors++;
                    $display("FAIL count_gated: gated=%h required f", g_o[0]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_o[0][i] !== 16'd5) begin
                errors++;
                $display("FAIL count_five ch%0d: cnt=%0d required 5", i, c_o[0][i]);
            end
        end
        $display("test_count: cnt0=%0d", c_o[0][0]);
    endtask

    task automatic test_mask();
        // Continues from test_count: all channels at 5, data all high.
        mask_wr = 1'b1; mask_din = 4'b0101;
        cycle();
        mask_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_o[0][i] !== 16'd6) begin
                errors++;
                $display("FAIL mask_load_cycle ch%0d: cnt=%0d required 6", i, c_o[0][i]);
            end
        end
        repeat (3) cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_o[0][i] !== ((i % 2 == 0) ? 16'd9 : 16'd6)) begin
                errors++;
                $display("FAIL mask_after ch%0d: cnt=%0d required %0d", i, c_o[0][i], (i % 2 == 0) ? 9 : 6);
            end
        end
        checks++;
        if (g_o[0] !== 4'b0101) begin
            errors++;
            $display("FAIL mask_gated: gated=%h required 5", g_o[0]);
        end
        $display("test_mask: cnt=%0d/%0d/%0d/%0d", c_o[0][0], c_o[0][1], c_o[0][2], c_o[0][3]);
    endtask

    task automatic test_saturate();
        do_reset();
        data = 4'b0001;
        repeat (20) cycle();
        checks++;
        if (c_o[1][0] !== 16'd15 || sat_o[1][0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d sat=%b required 15 and 1", c_o[1][0], sat_o[1][0]);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checks++;
        if (c_o[1][0] !== 16'd0 || sat_o[1][0] !== 1'b0 || c_o[0][0] !== 16'd0) begin
            errors++;
            $display("FAIL sat_clr: cnt=%0d sat=%b cnt_cfg0=%0d required 0 0 0", c_o[1][0], sat_o[1][0], c_o[0][0]);
        end
        checks++;
        if (g_o[1] !== 4'b0001) begin
            errors++;
            $display("FAIL clr_gated: gated=%h required 1", g_o[1]);
        end
        $display("test_saturate: done");
    endtask

    task automatic test_edge();
        bit pat [6] = '{1, 1, 0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            data = {3'b000, pat[k]};
            cycle();
        end
        data = 4'h0;
        checks++;
        if (c_o[2][0] !== 16'd3) begin
            errors++;
            $display("FAIL edge_count: cnt=%0d required 3", c_o[2][0]);
        end
        checks++;
        if (c_o[0][0] !== 16'd4) begin
            errors++;
            $display("FAIL level_count: cnt=%0d required 4", c_o[0][0]);
        end
        $display("test_edge: cnt_edge=%0d", c_o[2][0]);
    endtask

    task automatic test_snap_clr();
        do_reset();
        data = 4'b0001;
        repeat (7) cycle();
        data = 4'b0001; snap_req = 1'b1; clr = 1'b1;
        cycle();
        snap_req = 1'b0; clr = 1'b0; data = 4'h0;
        checks++;
        if (sv_o[0] !== 1'b1 || s_o[0][0] !== 16'd7 || c_o[0][0] !== 16'd0) begin
            errors++;
            $display("FAIL snap_clr: sv=%b snap=%0d cnt=%0d required 1 7 0", sv_o[0], s_o[0][0], c_o[0][0]);
        end
        cycle();
        checks++;
        if (sv_o[0] !== 1'b0 || s_o[0][0] !== 16'd7) begin
            errors++;
            $display("FAIL snap_hold: sv=%b snap=%0d required 0 7", sv_o[0], s_o[0][0]);
        end
        $display("test_snap_clr: snap=%0d", s_o[0][0]);
    endtask

    task automatic test_back_to_back();
        do_reset();
        data = 4'hF; snap_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++;
            if (sv_o[0] !== 1'b1 || s_o[0][1] !== 16'(k - 1)) begin
                errors++;
                $display("FAIL snap_b2b %0d: sv=%b snap=%0d required 1 %0d", k, sv_o[0], s_o[0][1], k - 1);
            end
        end
        snap_req = 1'b0;
        cycle();
        checks++;
        if (sv_o[0] !== 1'b0 || s_o[0][1] !== 16'd2) begin
            errors++;
            $display("FAIL snap_b2b_end: sv=%b snap=%0d required 0 2", sv_o[0], s_o[0][1]);
        end
        $display("test_back_to_back: last snap=%0d", s_o[0][1]);
    endtask

    task automatic test_async_reset();
        do_reset();
        mask_wr = 1'b1; mask_din = 4'h0; data = 4'hF;
        cycle();
        mask_wr = 1'b0;
        cycle();
        checks++;
        if (g_o[0] !== 4'h0) begin
            errors++;
            $display("FAIL zero_mask_gated: gated=%h required 0", g_o[0]);
        end
        snap_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (g_o[c] !== 4'h0 || sat_o[c] !== 4'h0 || sv_o[c] !== 1'b0 ||
                c_o[c][0] !== 16'd0 || c_o[c][3] !== 16'd0 || s_o[c][0] !== 16'd0) begin
                errors++;
                $display("FAIL async_reset cfg%0d: gated=%h sat=%h sv=%b cnt0=%0d required all 0",
                         c, g_o[c], sat_o[c], sv_o[c], c_o[c][0]);
            end
        end
        @(negedge clk);
        checks++;
        if (sv_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_snap: sv=%b required 0", sv_o[0]);
        end
        rst_n = 1'b1; snap_req = 1'b0; data = 4'hF;
        cycle();
        checks++;
        if (g_o[0] !== 4'hF || c_o[0][2] !== 16'd1) begin
            errors++;
            $display("FAIL mask_restored: gated=%h cnt2=%0d required f 1", g_o[0], c_o[0][2]);
        end
        $display("test_async_reset: gated=%h", g_o[0]);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            data     = 4'($urandom);
            mask_wr  = ($urandom_range(0, 9) == 0);
            mask_din = 4'($urandom);
            clr      = ($urandom_range(0, 24) == 0);
            snap_req = ($urandom_range(0, 2) == 0);
            cycle();
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (g_o[c] !== m_prev_q || sv_o[c] !== m_sv) begin
                    errors++; bad++;
                    $display("FAIL rand_flags cyc%0d cfg%0d: gated=%h sv=%b required %h %b",
                             k, c, g_o[c], sv_o[c], m_prev_q, m_sv);
                end
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if ({16'd0, c_o[c][i]} !== m_cnt[c][i] || sat_o[c][i] !== m_sat[c][i] ||
                        {16'd0, s_o[c][i]} !== m_snap[c][i]) begin
                        errors++; bad++;
                        $display("FAIL rand_cnt cyc%0d cfg%0d ch%0d: cnt=%0d sat=%b snap=%0d required %0d %b %0d",
                                 k, c, i, c_o[c][i], sat_o[c][i], s_o[c][i], m_cnt[c][i], m_sat[c][i], m_snap[c][i]);
                    end
                end
            end
        end
        idle_inputs();
        $display("test_random: 400 cycles, %0d mismatching checks", bad);
    endtask

    initial begin
        test_reset();
        test_count();
        test_mask();
        test_saturate();
        test_edge();
        test_snap_clr();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/masked_event_counter.md
MASKED_EVENT_COUNTER -- requirements
Module: masked_event_counter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, number of input channels (1..32).
REQ-002 The block SHALL provide parameter CNT_W, default 8, per-channel counter width (2..16).
REQ-003 The block SHALL provide parameter MASK_RST, default all-ones (WIDTH bits), mask register value after reset.
REQ-004 The block SHALL provide parameter EDGE_MODE, default 0; 0 counts every qualified cycle, 1 counts qualified rising edges only.
REQ-005 The block SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 The block SHALL have port data, input, WIDTH, per-channel event level.
REQ-008 The block SHALL have port mask_wr, input, 1, mask load strobe.
REQ-009 The block SHALL have port mask_din, input, WIDTH, new mask value.
REQ-010 The block SHALL have port clr, input, 1, synchronous clear of counters and saturation flags.
REQ-011 The block SHALL have port snap_req, input, 1, snapshot request.
REQ-012 The block SHALL have port gated, output, WIDTH, registered mask & data.
REQ-013 The block SHALL have port cnt, output, WIDTH*CNT_W, live counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 The block SHALL have port sat, output, WIDTH, sticky per-channel saturation flags.
REQ-015 The block SHALL have port snap_data, output, WIDTH*CNT_W, snapshot of counters, same packing as cnt.
REQ-016 The block SHALL have port snap_valid, output, 1, one-cycle qualifier for snap_data.

Function
REQ-017 Every register read in the clocked logic, including the mask, SHALL have an explicit reset value; no state SHALL depend on initial statements.
REQ-018 The mask SHALL load mask_din on a cycle with mask_wr=1; the new value SHALL take effect from the next cycle, and the load cycle itself SHALL use the old mask.
REQ-019 Qualified event q[i] SHALL be mask[i] & data[i] using the current mask register value.
REQ-020 gated SHALL register q, one-cycle latency.
REQ-021 With EDGE_MODE=0, counter i SHALL increment on every cycle where q[i]=1.
REQ-022 With EDGE_MODE=1, counter i SHALL increment on cycles where q[i]=1 and gated[i]=0 (previous cycle's q).
REQ-023 A counter at 2^CNT_W-1 SHALL hold its value on a further increment and set sat[i]; sat[i] SHALL remain set until clr or reset.
REQ-024 clr=1 SHALL zero all counters and sat on the next edge; clr SHALL take priority over a same-cycle increment, so the counter reads 0 afterwards.
REQ-025 clr SHALL NOT affect mask, gated or the edge-detect history.
REQ-026 snap_req=1 SHALL load snap_data with the cnt value present in that cycle (pre-increment, pre-clear) and assert snap_valid for exactly the next cycle.
REQ-027 snap_req held high for N cycles SHALL produce N consecutive snap_valid cycles, each carrying the corresponding cycle's counts.
REQ-028 snap_data SHALL hold its last value while snap_valid=0.
REQ-029 mask_wr, clr and snap_req in the same cycle SHALL all take effect as if applied independently per REQ-018, REQ-024 and REQ-026.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, set mask=MASK_RST, gated=0, cnt=0, sat=0, snap_data=0 and snap_valid=0.
REQ-031 Reset asserted mid-count or mid-snapshot SHALL abandon the operation; snap_valid SHALL NOT assert for a request made in the cycle in which reset is asserted.
REQ-032 The first edge after rst_n rises SHALL operate normally; in EDGE_MODE=1, data high at that edge SHALL count as an edge, because the history is reset to 0.

Verification
REQ-033 Reset, then WIDTH=4, EDGE_MODE=0, data=4'b1111 for 5 cycles with the default mask -> every channel count=5 and gated=4'b1111 one cycle after data is applied.
REQ-034 mask_wr=1 with mask_din=4'b0101 while data=4'b1111 is held -> channels 1 and 3 stop incrementing starting the cycle after the load; the load cycle still counts all four channels.
REQ-035 CNT_W=4, channel 0 held high for 20 cycles -> cnt0=15 and sat[0]=1; then clr=1 -> cnt0=0 and sat[0]=0; clr with q[0]=1 in the same cycle -> cnt0=0.
REQ-036 EDGE_MODE=1, data[0] pattern 1,1,0,1,0,1 from reset -> cnt0=3.
REQ-037 cnt0=7, snap_req and clr in the same cycle -> snap_data channel 0=7 with snap_valid high for 1 cycle, and cnt0=0.
REQ-038 rst_n pulsed low asynchronously between clock edges after the mask is loaded to 4'b0000 -> mask reads back as all-ones, and all outputs go to 0 before the next edge.
